// File: rtl/pin_entry_pkg.sv
// Shared types and constants for the keypad PIN entry controller.
package pin_entry_pkg;

  localparam int               DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_BCD = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    CHECK,
    PASS,
    FAIL
  } pin_state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] digit);
    return digit <= MAX_BCD;
  endfunction

endpackage

// File: rtl/pin_entry_controller_if.sv
// Keypad / payment-FSM / card-PIN signal bundle for pin_entry_controller.
interface pin_entry_controller_if #(
  parameter int PIN_DIGITS = 4
);
  import pin_entry_pkg::*;

  localparam int CNT_W = $clog2(PIN_DIGITS + 1);

  logic                          pin_process_init;
  logic                          process_abort;
  logic                          key_valid;
  logic [DIGIT_W-1:0]            key_digit;
  logic                          key_enter;
  logic                          key_clear;
  logic [DIGIT_W*PIN_DIGITS-1:0] ref_pin;
  logic                          ref_pin_valid;
  logic                          entry_active;
  logic [CNT_W-1:0]              digit_count;
  logic                          pin_success;
  logic                          pin_fail;

  // master: payment FSM + keypad side; slave: the PIN entry controller
  modport master (
    output pin_process_init, process_abort, key_valid, key_digit, key_enter, key_clear,
           ref_pin, ref_pin_valid,
    input  entry_active, digit_count, pin_success, pin_fail
  );

  modport slave (
    input  pin_process_init, process_abort, key_valid, key_digit, key_enter, key_clear,
           ref_pin, ref_pin_valid,
    output entry_active, digit_count, pin_success, pin_fail
  );

endinterface

// File: rtl/pin_digit_buffer.sv
// Entered-digit shift register with saturating count and overflow / non-BCD flags.
module pin_digit_buffer
  import pin_entry_pkg::*;
#(
  parameter  int PIN_DIGITS = 4,
  localparam int BUF_W      = DIGIT_W * PIN_DIGITS,
  localparam int CNT_W      = $clog2(PIN_DIGITS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [BUF_W-1:0]   digits_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               overflow_o,
  output logic               bad_o
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(PIN_DIGITS);

  logic [BUF_W-1:0] digits_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             bad_q;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      digits_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
    end else if (push_i) begin
      if (!is_bcd(digit_i)) begin
        bad_q <= 1'b1;
      end else if (count_q == FULL) begin
        overflow_q <= 1'b1;
      end else begin
        // first-entered digit ends up in the most significant nibble
        digits_q <= (digits_q << DIGIT_W) | BUF_W'(digit_i);
        count_q  <= count_q + 1'b1;
      end
    end
  end

  assign digits_o   = digits_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign bad_o      = bad_q;

endmodule

// File: rtl/pin_entry_controller.sv
// PIN collection/verification FSM with registered pass/fail pulses.
// Optional inactivity timeout in COLLECT is enabled by defining PIN_TIMEOUT_EN.
module pin_entry_controller
  import pin_entry_pkg::*;
#(
  parameter int PIN_DIGITS = 4
`ifdef PIN_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  pin_entry_controller_if.slave  bus
);

  localparam int               BUF_W = DIGIT_W * PIN_DIGITS;
  localparam int               CNT_W = $clog2(PIN_DIGITS + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(PIN_DIGITS);

  pin_state_t       state_q, state_d;
  logic             buf_clr, buf_push;
  logic [BUF_W-1:0] digits;
  logic [CNT_W-1:0] count;
  logic             overflow, bad;
  logic             match, timeout_hit;
  logic             success_q, fail_q, active_q;

  pin_digit_buffer #(.PIN_DIGITS(PIN_DIGITS)) u_digit_buffer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (buf_clr),
    .push_i     (buf_push),
    .digit_i    (bus.key_digit),
    .digits_o   (digits),
    .count_o    (count),
    .overflow_o (overflow),
    .bad_o      (bad)
  );

  assign match = bus.ref_pin_valid && (count == FULL) && !overflow && !bad &&
                 (digits == bus.ref_pin);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    buf_clr  = 1'b0;
    buf_push = 1'b0;
    if (bus.process_abort) begin
      state_d = IDLE;
    end else if (bus.pin_process_init) begin
      state_d = COLLECT;
      buf_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        COLLECT: begin
          if (bus.key_valid) begin
            if (bus.key_clear)      buf_clr  = 1'b1;
            else if (bus.key_enter) state_d  = CHECK;
            else                    buf_push = 1'b1;
          end else if (timeout_hit) begin
            state_d = FAIL;
          end
        end
        CHECK:      state_d = match ? PASS : FAIL;
        PASS, FAIL: state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
    // the entered digits never linger once the block is idle
    if (state_d == IDLE) buf_clr = 1'b1;
  end

`ifdef PIN_TIMEOUT_EN
  localparam int               TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] timer_q, timer_d;

  assign timeout_hit = (timer_q == TMR_LAST);

  // any key event, restart or leaving COLLECT returns the timer to zero
  always_comb begin
    timer_d = '0;
    if (state_q == COLLECT && state_d == COLLECT && !bus.key_valid && !bus.pin_process_init)
      timer_d = timer_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      success_q <= 1'b0;
      fail_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      success_q <= (state_d == PASS);
      fail_q    <= (state_d == FAIL);
      active_q  <= (state_d == COLLECT);
    end
  end

  assign bus.entry_active = active_q;
  assign bus.digit_count  = count;
  assign bus.pin_success  = success_q;
  assign bus.pin_fail     = fail_q;

endmodule
